// File: rtl/handshake_pkg.sv
// Shared types for the four-phase req/ack handshake endpoints.
package handshake_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2
  } hs_rx_state_t;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_multi.sv
// Multi-flop level synchronizer; dest is src delayed by STAGES dest_clk edges.
module sync_multi #(
  parameter int STAGES = 2
) (
  input  logic rst,
  input  logic src,
  input  logic dest_clk,
  output logic dest
);

  logic [STAGES-1:0] r_sync;

  // Shift chain with synchronous clear.
  always_ff @(posedge dest_clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], src};
    end
  end

  assign dest = r_sync[STAGES-1];

endmodule

// File: rtl/handshake_rx.sv
// Destination side of the four-phase bundled-data handshake: synchronizes the
// request, captures the word into a one-entry buffer and streams it out.
module handshake_rx
  import handshake_pkg::*;
#(
  parameter int BITWIDTH    = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                i_rd_clk,
  input  logic                i_rst,
  input  logic                i_src_req,
  input  logic [BITWIDTH-1:0] i_src_data,
  output logic                o_dest_ack,
  output logic                o_rd_stream_valid,
  input  logic                i_rd_stream_ready,
  output logic [BITWIDTH-1:0] o_rd_stream_data,
  output logic [CNT_W-1:0]    o_xfer_count,
  output logic                o_proto_err
);

  hs_rx_state_t        r_state;
  hs_rx_state_t        w_state_nxt;
  logic                w_req_s;
  logic                w_ok;
  logic                w_capture;
  logic                w_err;
  logic                r_dest_ack;
  logic                r_buf_valid;
  logic [BITWIDTH-1:0] r_data_q;
  logic [CNT_W-1:0]    r_xfer_count;
  logic                r_proto_err;

  sync_multi #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .rst      (i_rst),
    .src      (i_src_req),
    .dest_clk (i_rd_clk),
    .dest     (w_req_s)
  );

  assign w_ok = r_buf_valid & i_rd_stream_ready;

  // Next-state decode; a drained buffer or a same-cycle ok both free the slot.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_s && (!r_buf_valid || w_ok)) begin
          w_state_nxt = CAPTURE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CAPTURE: begin
        if (w_req_s) begin
          w_state_nxt = ACK;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_err       = 1'b1;
        end
      end
      ACK: begin
        if (!w_req_s) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = ACK;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, buffer, ack and status registers; ack is decoded from next state.
  always_ff @(posedge i_rd_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_dest_ack   <= 1'b0;
      r_buf_valid  <= 1'b0;
      r_data_q     <= '0;
      r_xfer_count <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dest_ack <= (w_state_nxt == ACK);
      if (w_capture) begin
        r_data_q    <= i_src_data;
        r_buf_valid <= 1'b1;
      end else if (w_ok) begin
        r_buf_valid <= 1'b0;
      end else begin
        r_buf_valid <= r_buf_valid;
      end
      if (w_ok) begin
        r_xfer_count <= r_xfer_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_xfer_count <= r_xfer_count;
      end
      if (w_err) begin
        r_proto_err <= 1'b1;
      end else begin
        r_proto_err <= r_proto_err;
      end
    end
  end

  assign o_dest_ack        = r_dest_ack;
  assign o_rd_stream_valid = r_buf_valid;
  assign o_rd_stream_data  = r_data_q;
  assign o_xfer_count      = r_xfer_count;
  assign o_proto_err       = r_proto_err;

endmodule
